aximm_window_ctl: RTL and testbench
===================================

Name: aximm_window_ctl

Overview:
- AXI4-Lite control slave that owns the sliding-window base address consumed by the downstream AXI-MM window-translation stage (its window_addr input).
- Software stages a new 64-bit window, then requests a commit. The block blocks new AXI-MM requests, waits for all outstanding bursts on the translated bus to drain, and only then applies the new window, so no burst is split across two windows.
- Sits between the PCIe/AXI-Lite config path and the window stage.

Parameters:
- AW, 64, width of window_addr and staged registers.
- WINDOW_INIT, 64'h0, value of window_addr and staged registers after reset.
- CW, 8, width of outstanding-transaction counters.
- ALIGN_BITS, 20, low address bits forced to zero when WINDOW_ALIGN_EN is defined.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  4  AXI-Lite write address (bits [3:2] used).
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  always OKAY (2'b00).
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always OKAY.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake.
- mon_awvalid, mon_awready, mon_bvalid, mon_bready  in  1 each  monitored write channels of the translated AXI-MM bus.
- mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast  in  1 each  monitored read channels.
- window_addr  out  AW  active window base, registered.
- hold  out  1  registered; upstream must gate AWVALID/ARVALID while high.
- window_updated  out  1  one-cycle pulse when window_addr changes.

Behaviour:
- Reset (resetn low, async): window_addr = staged = WINDOW_INIT; hold = 0; window_updated = 0; all S_AXI valid/ready outputs = 0; counters = 0; overflow = 0; state = IDLE.
- Register map (32-bit):
  - 0x0 STAGE_LO = staged[31:0].
  - 0x4 STAGE_HI = staged[63:32].
  - 0x8 CTRL: write bit0 = 1 requests a commit. Read: bit0 = pending (state != IDLE), bit1 = bus idle (both counters 0).
  - 0xC STATUS, read-only: [7:0] wr_cnt, [15:8] rd_cnt, [16] overflow (sticky, cleared by writing 1 to STATUS bit16).
- WSTRB applies per byte on STAGE_LO and STAGE_HI; CTRL and STATUS act on WSTRB[0] and WSTRB[2] respectively.
- AXI-Lite write path:
  - AWREADY and WREADY assert together for one cycle only when AWVALID && WVALID && !BVALID.
  - BVALID rises the following cycle and holds until BREADY.
- AXI-Lite read path:
  - ARREADY is a one-cycle pulse when ARVALID && !RVALID.
  - RDATA/RVALID are registered the next cycle and held until RREADY.
  - Read latency is 1 cycle.
- Counters:
  - wr_cnt: +1 on mon AW handshake, −1 on mon B handshake. Both in the same cycle leaves it unchanged.
  - rd_cnt: +1 on mon AR handshake, −1 on mon R handshake with rlast.
  - An increment at all-ones is dropped and sets overflow.
  - A decrement at 0 is dropped and sets overflow.
- Commit FSM:
  - IDLE: a CTRL write with bit0 = 1 → DRAIN; hold = 1 from the next cycle.
  - DRAIN: when wr_cnt == 0, rd_cnt == 0, and no mon AW/AR handshake occurs this cycle → APPLY.
  - APPLY (one cycle): window_addr ← staged (masked if WINDOW_ALIGN_EN); window_updated = 1; hold = 0 next cycle → IDLE.
  - Minimum commit latency on an idle bus: CTRL write handshake → window_addr change in 3 cycles.
- Boundary conditions:
  - A CTRL commit write while not IDLE is ignored.
  - STAGE writes during DRAIN are accepted; the value in staged at APPLY is the one applied.
  - Reset mid-DRAIN returns to IDLE with window_addr = WINDOW_INIT.
  - Unmapped bits read as 0.

Optional Feature:
- Macro WINDOW_ALIGN_EN.
- Defined: staged[ALIGN_BITS-1:0] reads back and applies as 0, so the window is aligned to 2^ALIGN_BITS.
- Undefined: all AW bits of staged are stored and applied unmodified.

Test Plan:
- Reset → window_addr = WINDOW_INIT, hold = 0, all reads of STATUS return 0.
- Write STAGE_LO = 0x0040_0000, STAGE_HI = 0x1, CTRL = 1 on idle bus → window_updated pulses once; window_addr = 0x1_0040_0000 exactly 3 cycles after the CTRL handshake.
- Two mon AWs and one AR accepted, then CTRL = 1 → hold stays 1, window_addr unchanged until both B and RLAST complete; APPLY occurs the cycle after rd_cnt and wr_cnt both reach 0.
- Simultaneous mon AW and B handshakes with wr_cnt = 3 → wr_cnt remains 3; 256 AWs with no B → overflow = 1, wr_cnt = 255.
- Second CTRL = 1 during DRAIN, plus a STAGE_LO write of 0x1234_5000 → single window_updated pulse; applied value contains 0x1234_5000.
- With WINDOW_ALIGN_EN, write STAGE_LO = 0xFFFF_FFFF → read-back value = 0xFFF0_0000; committed window_addr[19:0] = 0.

Source files
------------

// File: rtl/aximm_window_ctl_if.sv
// aximm_window_ctl_if: AXI4-Lite control port bundle for the window controller
interface aximm_window_ctl_if;
  logic [3:0] awaddr;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [3:0] araddr;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/aximm_window_ctl.sv
// aximm_window_ctl: AXI-Lite staged window base, applied only once the translated bus drains.
// Optional macro WINDOW_ALIGN_EN forces staged[ALIGN_BITS-1:0] to zero on read-back and apply.
module aximm_window_ctl #(
  parameter int AW = 64,
  parameter logic [AW-1:0] WINDOW_INIT = '0,
  parameter int CW = 8,
  parameter int ALIGN_BITS = 20
) (
  input  logic clk,
  input  logic resetn,
  aximm_window_ctl_if.slave s_axi,
  input  logic mon_awvalid,
  input  logic mon_awready,
  input  logic mon_bvalid,
  input  logic mon_bready,
  input  logic mon_arvalid,
  input  logic mon_arready,
  input  logic mon_rvalid,
  input  logic mon_rready,
  input  logic mon_rlast,
  output logic [AW-1:0] window_addr,
  output logic hold,
  output logic window_updated
);
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;
`ifdef WINDOW_ALIGN_EN
  localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << ALIGN_BITS;
`else
  localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}};
`endif
  state_t state, state_nxt;
  logic [AW-1:0] staged;
  logic [63:0] stg, stg_nxt;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic overflow;
  logic wr_hs, rd_hs, commit, ovf_clr, drained, bus_idle;
  logic wr_inc, wr_dec, rd_inc, rd_dec, wr_ovf, rd_ovf;
  logic [31:0] rd_mux;
  logic unused;
  assign unused = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};
  assign s_axi.wready = s_axi.awready;
  assign s_axi.bresp = 2'b00;
  assign s_axi.rresp = 2'b00;
  assign wr_hs = s_axi.awready && s_axi.awvalid && s_axi.wvalid;
  assign rd_hs = s_axi.arready && s_axi.arvalid;
  assign commit = wr_hs && s_axi.awaddr[3:2] == 2'd2 && s_axi.wstrb[0] && s_axi.wdata[0];
  assign ovf_clr = wr_hs && s_axi.awaddr[3:2] == 2'd3 && s_axi.wstrb[2] && s_axi.wdata[16];
  assign wr_inc = mon_awvalid && mon_awready;
  assign wr_dec = mon_bvalid && mon_bready;
  assign rd_inc = mon_arvalid && mon_arready;
  assign rd_dec = mon_rvalid && mon_rready && mon_rlast;
  assign wr_ovf = (wr_inc && !wr_dec && &wr_cnt) || (wr_dec && !wr_inc && wr_cnt == '0);
  assign rd_ovf = (rd_inc && !rd_dec && &rd_cnt) || (rd_dec && !rd_inc && rd_cnt == '0);
  assign bus_idle = wr_cnt == '0 && rd_cnt == '0;
  // a burst accepted in the same cycle would otherwise escape the drain
  assign drained = bus_idle && !wr_inc && !rd_inc;
  assign stg = 64'(staged & ALIGN_MASK);
  always_comb begin
    stg_nxt = stg;
    for (int i = 0; i < 8; i++)
      if (wr_hs && s_axi.awaddr[3:2] == 2'(i / 4) && s_axi.wstrb[i % 4])
        stg_nxt[8*i +: 8] = s_axi.wdata[8*(i % 4) +: 8];
  end
  always_comb begin
    rd_mux = s_axi.araddr[3:2] == 2'd0 ? stg[31:0] :
             s_axi.araddr[3:2] == 2'd1 ? stg[63:32] :
             s_axi.araddr[3:2] == 2'd2 ? {30'b0, bus_idle, state != IDLE} :
             {15'b0, overflow, 8'(rd_cnt), 8'(wr_cnt)};
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (commit ? DRAIN : IDLE) :
                state == DRAIN ? (drained ? APPLY : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hold <= 1'b0;
      window_updated <= 1'b0;
      window_addr <= WINDOW_INIT;
      staged <= WINDOW_INIT;
    end else begin
      state <= state_nxt;
      hold <= state_nxt != IDLE;
      window_updated <= state == APPLY;
      window_addr <= state == APPLY ? AW'(stg) : window_addr;
      staged <= AW'(stg_nxt);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wr_cnt <= (wr_inc && !wr_dec && !(&wr_cnt)) ? wr_cnt + 1'b1 :
                (wr_dec && !wr_inc && wr_cnt != '0) ? wr_cnt - 1'b1 : wr_cnt;
      rd_cnt <= (rd_inc && !rd_dec && !(&rd_cnt)) ? rd_cnt + 1'b1 :
                (rd_dec && !rd_inc && rd_cnt != '0) ? rd_cnt - 1'b1 : rd_cnt;
      overflow <= wr_ovf || rd_ovf || (overflow && !ovf_clr);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axi.awready <= 1'b0;
      s_axi.bvalid <= 1'b0;
      s_axi.arready <= 1'b0;
      s_axi.rvalid <= 1'b0;
      s_axi.rdata <= '0;
    end else begin
      s_axi.awready <= s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid && !s_axi.awready;
      s_axi.bvalid <= wr_hs ? 1'b1 : s_axi.bready ? 1'b0 : s_axi.bvalid;
      s_axi.arready <= s_axi.arvalid && !s_axi.rvalid && !s_axi.arready;
      s_axi.rvalid <= rd_hs ? 1'b1 : s_axi.rready ? 1'b0 : s_axi.rvalid;
      s_axi.rdata <= rd_hs ? rd_mux : s_axi.rdata;
    end
  end
endmodule

// File: tb/tb_aximm_window_ctl.sv
// tb_aximm_window_ctl: scoreboard bench for the staged-window commit controller
module tb_aximm_window_ctl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  aximm_window_ctl_if bus ();
  logic mon_awvalid = 0, mon_awready = 0, mon_bvalid = 0, mon_bready = 0;
  logic mon_arvalid = 0, mon_arready = 0, mon_rvalid = 0, mon_rready = 0, mon_rlast = 0;
  logic [63:0] window_addr;
  logic hold, window_updated;
  aximm_window_ctl dut (
    .clk(clk), .resetn(resetn), .s_axi(bus),
    .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
    .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .window_addr(window_addr), .hold(hold), .window_updated(window_updated)
  );
  typedef struct {logic [3:0] a; logic [31:0] d;} rexp_t;
  rexp_t rq[$];
  rexp_t re;
  logic [63:0] uq[$];
  logic [63:0] stg_m = '0;
  int checks = 0, errors = 0, cyc = 0, last_ref = 0, upd_cnt = 0;
  int m_wr = 0, m_rd = 0;
  bit m_ovf = 0, m_pend = 0, lat_chk = 0;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] am(input logic [63:0] v);
`ifdef WINDOW_ALIGN_EN
    return v & ~64'hF_FFFF;
`else
    return v;
`endif
  endfunction
  function automatic logic [31:0] status_m();
    return {15'b0, m_ovf, 8'(m_rd), 8'(m_wr)};
  endfunction
  function automatic logic [31:0] ctrl_m();
    return {30'b0, m_wr == 0 && m_rd == 0, m_pend};
  endfunction
  always @(negedge clk) begin
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) check("rd_extra", 1, 0);
      else begin
        re = rq.pop_front();
        check($sformatf("rd_%0h", re.a), bus.rdata, re.d);
      end
    end
    if (window_updated) begin
      upd_cnt++;
      m_pend = 0;
      if (uq.size() == 0) check("upd_extra", 1, 0);
      else check("win", window_addr, uq.pop_front());
      if (lat_chk) check("lat", cyc, last_ref + 3);
    end
  end
  task automatic axw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    if (a[3] == 1'b0) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) stg_m[(a[2] ? 32 : 0) + 8*i +: 8] = d[8*i +: 8];
      stg_m = am(stg_m);
      if (m_pend && uq.size() > 0) uq[uq.size()-1] = stg_m;
    end
    if (a == 4'h8 && s[0] && d[0] && !m_pend) begin
      m_pend = 1;
      uq.push_back(stg_m);
    end
    if (a == 4'hC && s[2] && d[16]) m_ovf = 0;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1; bus.wvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
    check("awready", bus.awready, 1);
    last_ref = cyc;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.bvalid && t < 20);
    check("bvalid_bresp", {bus.bvalid, bus.bresp}, 3'b100);
  endtask
  task automatic axr(input logic [3:0] a, input logic [31:0] e);
    int t;
    rq.push_back('{a, e});
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.arready && t < 20);
    check("arready", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.rvalid && t < 20);
    check("rvalid_rresp", {bus.rvalid, bus.rresp}, 3'b100);
  endtask
  task automatic mon(input bit aw, input bit b, input bit ar, input bit r, input bit last, input int n);
    @(negedge clk);
    {mon_awvalid, mon_awready} = {2{aw}};
    {mon_bvalid, mon_bready} = {2{b}};
    {mon_arvalid, mon_arready} = {2{ar}};
    {mon_rvalid, mon_rready} = {2{r}};
    mon_rlast = last;
    for (int i = 0; i < n; i++) begin
      if (aw && !b) begin if (m_wr == 255) m_ovf = 1; else m_wr++; end
      else if (b && !aw) begin if (m_wr == 0) m_ovf = 1; else m_wr--; end
      if (ar && !(r && last)) begin if (m_rd == 255) m_ovf = 1; else m_rd++; end
      else if (r && last && !ar) begin if (m_rd == 0) m_ovf = 1; else m_rd--; end
      @(negedge clk);
    end
    {mon_awvalid, mon_awready, mon_bvalid, mon_bready} = '0;
    {mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast} = '0;
  endtask
  initial begin
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 1;
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 1;
    repeat (3) @(negedge clk);
    resetn = 1;
    check("rst_win", window_addr, 0);
    check("rst_hold", hold, 0);
    check("rst_upd", window_updated, 0);
    check("rst_ready", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 0);
    axr(4'hC, 0);
    axr(4'h8, ctrl_m());
    axr(4'h0, 0);
    axr(4'h4, 0);
    // idle-bus commit: exact latency from the CTRL handshake
    axw(4'h0, 32'h0040_0000, 4'hF);
    axw(4'h4, 32'h1, 4'hF);
    axr(4'h0, stg_m[31:0]);
    axr(4'h4, stg_m[63:32]);
    lat_chk = 1;
    axw(4'h8, 32'h1, 4'h1);
    repeat (5) @(negedge clk);
    lat_chk = 0;
    check("upd_cnt1", upd_cnt, 1);
    check("win1", window_addr, 64'h1_0040_0000);
    check("hold1", hold, 0);
    // commit held off by outstanding bursts
    mon(1, 0, 0, 0, 0, 2);
    mon(0, 0, 1, 0, 0, 1);
    axr(4'hC, status_m());
    axw(4'h0, 32'hABC0_0000, 4'hF);
    axw(4'h8, 32'h1, 4'h1);
    repeat (4) @(negedge clk);
    check("drain_hold", hold, 1);
    check("drain_win", window_addr, 64'h1_0040_0000);
    axr(4'h8, ctrl_m());
    mon(0, 1, 0, 0, 0, 2);
    mon(0, 0, 0, 1, 0, 1);
    repeat (3) @(negedge clk);
    check("nolast_hold", hold, 1);
    check("nolast_upd", upd_cnt, 1);
    @(negedge clk);
    mon_rvalid = 1; mon_rready = 1; mon_rlast = 1; m_rd--;
    last_ref = cyc; lat_chk = 1;
    @(negedge clk);
    mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
    repeat (4) @(negedge clk);
    lat_chk = 0;
    check("drain_upd", upd_cnt, 2);
    check("drain_hold0", hold, 0);
    // counter corner cases
    mon(1, 0, 0, 0, 0, 3);
    mon(1, 1, 0, 0, 0, 1);
    axr(4'hC, status_m());
    mon(0, 1, 0, 0, 0, 3);
    mon(1, 0, 0, 0, 0, 256);
    axr(4'hC, status_m());
    axw(4'hC, 32'h1_0000, 4'b1011);
    axr(4'hC, status_m());
    axw(4'hC, 32'h1_0000, 4'b0100);
    axr(4'hC, status_m());
    mon(0, 1, 0, 0, 0, 256);
    axr(4'hC, status_m());
    axw(4'hC, 32'h1_0000, 4'b0100);
    mon(0, 0, 0, 1, 1, 1);
    axr(4'hC, status_m());
    axw(4'hC, 32'h1_0000, 4'b0100);
    axr(4'hC, status_m());
    axr(4'h8, ctrl_m());
    // repeated commit and restage during drain
    mon(1, 0, 0, 0, 0, 1);
    axw(4'h8, 32'h1, 4'h1);
    axw(4'h8, 32'h1, 4'h1);
    axw(4'h0, 32'h1234_5000, 4'hF);
    repeat (3) @(negedge clk);
    check("restage_upd", upd_cnt, 2);
    mon(0, 1, 0, 0, 0, 1);
    repeat (6) @(negedge clk);
    check("restage_upd2", upd_cnt, 3);
    check("restage_win", window_addr, stg_m);
    // strobes, alignment, and a commit write without WSTRB[0]
    axw(4'h0, 32'hFFFF_FFAA, 4'b0001);
    axr(4'h0, stg_m[31:0]);
    axw(4'h4, 32'hDEAD_BEEF, 4'b1100);
    axr(4'h4, stg_m[63:32]);
    axw(4'h0, 32'hFFFF_FFFF, 4'hF);
    axr(4'h0, stg_m[31:0]);
    axw(4'h8, 32'h1, 4'b1110);
    repeat (5) @(negedge clk);
    check("nostrb_upd", upd_cnt, 3);
    axw(4'h8, 32'h1, 4'h1);
    repeat (5) @(negedge clk);
    check("align_upd", upd_cnt, 4);
    check("align_win", window_addr, stg_m);
`ifdef WINDOW_ALIGN_EN
    check("align_lo0", window_addr[19:0], 0);
`endif
    // asynchronous reset in the middle of a drain
    mon(1, 0, 0, 0, 0, 1);
    axw(4'h8, 32'h1, 4'h1);
    repeat (2) @(negedge clk);
    #2 resetn = 0;
    #1;
    check("arst_win", window_addr, 0);
    check("arst_hold", hold, 0);
    m_wr = 0; m_rd = 0; m_ovf = 0; m_pend = 0; stg_m = '0;
    uq.delete();
    repeat (2) @(negedge clk);
    resetn = 1;
    axr(4'h8, ctrl_m());
    axr(4'h0, 0);
    axr(4'hC, status_m());
    repeat (3) @(negedge clk);
    check("arst_upd", upd_cnt, 4);
    check("uq_empty", uq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
